// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope controller: state encoding,
// accumulator/envelope widths and the sustain-target helper.
package adsr_pkg;

  localparam int ACC_WIDTH = 32;
  localparam int ENV_WIDTH = 16;

  // 1.0 in Q2.30 on the accumulator, 1.0 in Q2.14 on the envelope output
  localparam logic [ACC_WIDTH-1:0] ENV_MAX     = 32'h4000_0000;
  localparam logic [ENV_WIDTH-1:0] SUSTAIN_MAX = 16'h4000;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } adsr_state_t;

  // Sustain levels above unity are clamped so decay never targets above ENV_MAX.
  function automatic logic [ACC_WIDTH-1:0] sustain_target(input logic [ENV_WIDTH-1:0] lvl);
    logic [ENV_WIDTH-1:0] clamped;
    clamped = (lvl > SUSTAIN_MAX) ? SUSTAIN_MAX : lvl;
    return {clamped, {(ACC_WIDTH - ENV_WIDTH){1'b0}}};
  endfunction

endpackage

// File: rtl/adsr_ctrl_tick_gen.sv
// Free-running sample-rate divider: one-cycle o_sample_en every SAMPLE_DIV clocks,
// first pulse SAMPLE_DIV cycles after reset is released.
module tick_gen #(
  parameter int SAMPLE_DIV = 2268
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_sample_en
);

  localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count       <= '0;
      o_sample_en <= 1'b0;
    end else begin
      o_sample_en <= (count == LAST);
      count       <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adsr_ctrl.sv
// ADSR envelope controller producing a Q2.14 envelope and sample enable for a DDFS.
// Optional feature: define ADSR_AUTO_RELEASE_EN for timed auto-release out of SUSTAIN.
module adsr_ctrl
  import adsr_pkg::*;
#(
  parameter int SAMPLE_DIV = 2268
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_release,
  input  logic [31:0] i_attack_step,
  input  logic [31:0] i_decay_step,
  input  logic [31:0] i_release_step,
  input  logic [15:0] i_sustain_lvl,
`ifdef ADSR_AUTO_RELEASE_EN
  input  logic [15:0] i_sustain_ticks,
`endif
  output logic [15:0] o_env,
  output logic        o_sample_en,
  output logic        o_busy,
  output logic        o_done
);

  adsr_state_t          state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] atk_step;
  logic [ACC_WIDTH-1:0] dec_step;
  logic [ACC_WIDTH-1:0] rel_step;
  logic                 start_pend;
  logic                 rel_pend;
  logic                 sample_tick;
`ifdef ADSR_AUTO_RELEASE_EN
  logic [15:0]          hold_ticks;
  logic [15:0]          hold_cnt;
`endif

  logic [ACC_WIDTH:0]   atk_sum;
  logic [ACC_WIDTH:0]   dec_diff;
  logic [ACC_WIDTH-1:0] target;
  logic                 attack_done;
  logic                 decay_done;
  logic                 release_done;
  logic                 start_now;
  logic                 release_now;

  tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick_gen (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .o_sample_en (sample_tick)
  );

  assign o_sample_en = sample_tick;
  assign o_env       = acc[ACC_WIDTH-1 -: ENV_WIDTH];

  // One extra bit on each side exposes the carry / borrow directly.
  assign atk_sum  = {1'b0, acc} + {1'b0, atk_step};
  assign dec_diff = {1'b0, acc} - {1'b0, dec_step};
  assign target   = sustain_target(i_sustain_lvl);

  assign attack_done  = (atk_step == '0) || atk_sum[ACC_WIDTH] ||
                        (atk_sum[ACC_WIDTH-1:0] >= ENV_MAX);
  assign decay_done   = (dec_step == '0) || dec_diff[ACC_WIDTH] ||
                        (dec_diff[ACC_WIDTH-1:0] <= target);
  assign release_done = (rel_step == '0) || (acc <= rel_step);

  // A pulse arriving in the tick cycle itself is honoured on that tick.
  assign start_now   = start_pend | i_start;
  assign release_now = rel_pend | i_release;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      acc        <= '0;
      atk_step   <= '0;
      dec_step   <= '0;
      rel_step   <= '0;
      start_pend <= 1'b0;
      rel_pend   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
`ifdef ADSR_AUTO_RELEASE_EN
      hold_ticks <= '0;
      hold_cnt   <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      if (!sample_tick) begin
        start_pend <= start_pend | i_start;
        rel_pend   <= rel_pend | i_release;
      end else begin
        start_pend <= 1'b0;
        rel_pend   <= 1'b0;
        if (start_now) begin
          atk_step <= i_attack_step;
          dec_step <= i_decay_step;
          rel_step <= i_release_step;
`ifdef ADSR_AUTO_RELEASE_EN
          hold_ticks <= i_sustain_ticks;
`endif
          state  <= ATTACK;
          o_busy <= 1'b1;
        end else if (release_now &&
                     (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
          state <= RELEASE;
        end else begin
          case (state)
            IDLE: ;
            ATTACK: begin
              if (attack_done) begin
                acc   <= ENV_MAX;
                state <= DECAY;
              end else begin
                acc <= atk_sum[ACC_WIDTH-1:0];
              end
            end
            DECAY: begin
              if (decay_done) begin
                acc   <= target;
                state <= SUSTAIN;
`ifdef ADSR_AUTO_RELEASE_EN
                hold_cnt <= hold_ticks;
`endif
              end else begin
                acc <= dec_diff[ACC_WIDTH-1:0];
              end
            end
            SUSTAIN: begin
`ifdef ADSR_AUTO_RELEASE_EN
              // A zero hold count leaves the note sustaining until released.
              if (hold_ticks != '0) begin
                if (hold_cnt <= 16'd1) begin
                  state <= RELEASE;
                end else begin
                  hold_cnt <= hold_cnt - 16'd1;
                end
              end
`endif
            end
            RELEASE: begin
              if (release_done) begin
                acc    <= '0;
                state  <= IDLE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end else begin
                acc <= acc - rel_step;
              end
            end
            default: begin
              acc    <= '0;
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_adsr_ctrl.sv
// Scoreboard bench for adsr_ctrl: an arithmetic envelope model predicts each post-tick
// output, a monitor pops and compares; directed sequences pin the documented values.
`timescale 1ns/1ps
module tb_adsr_ctrl;

  localparam int     DIV  = 4;
  localparam longint ENVM = 64'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rel = 1'b0;
  logic [31:0] atk = '0;
  logic [31:0] dec = '0;
  logic [31:0] rls = '0;
  logic [15:0] sus = '0;
`ifdef ADSR_AUTO_RELEASE_EN
  logic [15:0] sus_ticks = '0;
`endif
  logic [15:0] env;
  logic        se;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adsr_ctrl #(.SAMPLE_DIV(DIV)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_start        (start),
    .i_release      (rel),
    .i_attack_step  (atk),
    .i_decay_step   (dec),
    .i_release_step (rls),
    .i_sustain_lvl  (sus),
`ifdef ADSR_AUTO_RELEASE_EN
    .i_sustain_ticks(sus_ticks),
`endif
    .o_env          (env),
    .o_sample_en    (se),
    .o_busy         (busy),
    .o_done         (done)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (phases of the envelope, plain arithmetic) -------------
  localparam int P_OFF = 0, P_UP = 1, P_DOWN = 2, P_HOLD = 3, P_FADE = 4;

  typedef struct {
    logic [15:0] env;
    bit          busy;
    bit          done;
  } exp_t;

  exp_t   sb[$];
  int     m_phase = P_OFF;
  longint m_acc = 0;
  longint m_atk = 0, m_dec = 0, m_rel = 0;
  bit     m_ps = 0, m_pr = 0, m_se = 0;
  int     m_cyc = 0;
  int     m_age = 0;
  int     m_hold_cap = 0;

  always @(posedge clk) begin
    bit     tick, s_eff, r_eff, m_done;
    longint tgt;
    exp_t   e;
    if (!rst_n) begin
      m_phase = P_OFF; m_acc = 0; m_ps = 0; m_pr = 0; m_cyc = 0; m_se = 0;
      sb.delete();
    end else begin
      tick = m_se;
      m_cyc++;
      m_se = (m_cyc % DIV == 0);
      if (tick) begin
        s_eff = m_ps | start;
        r_eff = m_pr | rel;
        m_ps = 0; m_pr = 0; m_done = 0;
        tgt = ((sus > 16'h4000) ? 64'h4000 : longint'(sus)) * 65536;
        if (s_eff) begin
          m_atk = atk; m_dec = dec; m_rel = rls;
`ifdef ADSR_AUTO_RELEASE_EN
          m_hold_cap = int'(sus_ticks);
`endif
          m_phase = P_UP;
        end else if (r_eff && (m_phase == P_UP || m_phase == P_DOWN || m_phase == P_HOLD)) begin
          m_phase = P_FADE;
        end else begin
          case (m_phase)
            P_UP:
              if (m_atk == 0 || m_acc + m_atk >= ENVM) begin m_acc = ENVM; m_phase = P_DOWN; end
              else m_acc = m_acc + m_atk;
            P_DOWN:
              if (m_dec == 0 || m_acc - m_dec <= tgt) begin m_acc = tgt; m_phase = P_HOLD; m_age = 0; end
              else m_acc = m_acc - m_dec;
            P_HOLD: begin
`ifdef ADSR_AUTO_RELEASE_EN
              m_age++;
              if (m_hold_cap != 0 && m_age == m_hold_cap) m_phase = P_FADE;
`endif
            end
            P_FADE:
              if (m_rel == 0 || m_acc <= m_rel) begin m_acc = 0; m_phase = P_OFF; m_done = 1; end
              else m_acc = m_acc - m_rel;
            default: ;
          endcase
        end
        e.env  = m_acc[31:16];
        e.busy = (m_phase != P_OFF);
        e.done = m_done;
        sb.push_back(e);
      end else begin
        m_ps = m_ps | start;
        m_pr = m_pr | rel;
      end
    end
  end

  // ---------------- monitor ----------------
  bit mon_prev_se = 0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      mon_prev_se = 0;
    end else begin
      check("sample_en", longint'(se), longint'(m_se));
      if (mon_prev_se) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 0, 1);
        end else begin
          e = sb.pop_front();
          check("env", longint'(env), longint'(e.env));
          check("busy", longint'(busy), longint'(e.busy));
          check("done", longint'(done), longint'(e.done));
        end
      end else begin
        check("done_idle", longint'(done), 0);
      end
      mon_prev_se = se;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_tick(output logic [15:0] t_env, output logic t_busy, output logic t_done);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!se && n < 3 * DIV);
    if (!se) check("tick_timeout", 1, 0);
    @(posedge clk); #1;
    t_env = env; t_busy = busy; t_done = done;
  endtask

  task automatic pulse(input bit s, input bit r);
    @(negedge clk); start = s; rel = r;
    @(negedge clk); start = 1'b0; rel = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expect the next tick to yield this envelope and busy flag.
  task automatic expect_tick(input string name, input logic [15:0] e_env, input bit e_busy);
    logic [15:0] t_env; logic t_busy, t_done;
    next_tick(t_env, t_busy, t_done);
    check({name, "_env"}, longint'(t_env), longint'(e_env));
    check({name, "_busy"}, longint'(t_busy), longint'(e_busy));
  endtask

  function automatic logic [31:0] rnd_step();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'h0;
    if (k == 1) return 32'hFFFF_FFFF;
    return $urandom >> $urandom_range(2, 6);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [15:0] seq_env [10] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000,
                                16'h3800, 16'h3000, 16'h2800, 16'h2000, 16'h2000};

  initial begin
    logic [15:0] t_env; logic t_busy, t_done;
    bit seen_done;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_env", longint'(env), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_se", longint'(se), 0);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      check($sformatf("tick_cycle%0d", c), longint'(se), longint'(c % DIV == 0));
    end
    check("idle_env", longint'(env), 0);
    check("idle_busy", longint'(busy), 0);

    // Full attack / decay / sustain
    next_tick(t_env, t_busy, t_done);
    atk = 32'h1000_0000; dec = 32'h0800_0000; rls = 32'h1000_0000; sus = 16'h2000;
    pulse(1, 0);
    for (int i = 0; i < 10; i++) expect_tick($sformatf("ads%0d", i), seq_env[i], 1'b1);

    // Release to idle
    pulse(0, 1);
    expect_tick("rel0", 16'h2000, 1'b1);
    expect_tick("rel1", 16'h1000, 1'b1);
    next_tick(t_env, t_busy, t_done);
    check("rel2_env", longint'(t_env), 0);
    check("rel2_done", longint'(t_done), 1);
    check("rel2_busy", longint'(t_busy), 0);
    next_tick(t_env, t_busy, t_done);
    check("rel3_done", longint'(t_done), 0);

    // Release during attack, then start+release together
    pulse(1, 0);
    expect_tick("ar0", 16'h0000, 1'b1);
    expect_tick("ar1", 16'h1000, 1'b1);
    expect_tick("ar2", 16'h2000, 1'b1);
    pulse(0, 1);
    expect_tick("ar3", 16'h2000, 1'b1);
    expect_tick("ar4", 16'h1000, 1'b1);
    pulse(1, 1);
    expect_tick("sr0", 16'h1000, 1'b1);
    expect_tick("sr1", 16'h2000, 1'b1);
    expect_tick("sr2", 16'h3000, 1'b1);

    // Carry clamp and sustain clamp
    atk = 32'hFFFF_FFFF; dec = 32'h0800_0000; sus = 16'h7FFF;
    pulse(1, 0);
    expect_tick("cc0", 16'h3000, 1'b1);
    expect_tick("cc1", 16'h4000, 1'b1);
    expect_tick("cc2", 16'h4000, 1'b1);
    expect_tick("cc3", 16'h4000, 1'b1);

    // Zero steps finish each phase in one tick
    atk = 32'h0; dec = 32'h0; rls = 32'h0; sus = 16'h1000;
    pulse(1, 0);
    expect_tick("z0", 16'h4000, 1'b1);
    expect_tick("z1", 16'h4000, 1'b1);
    expect_tick("z2", 16'h1000, 1'b1);
    pulse(0, 1);
    expect_tick("z3", 16'h1000, 1'b1);
    next_tick(t_env, t_busy, t_done);
    check("z4_env", longint'(t_env), 0);
    check("z4_done", longint'(t_done), 1);
    pulse(1, 0);
    expect_tick("z5", 16'h0000, 1'b1);
    expect_tick("z6", 16'h4000, 1'b1);

`ifdef ADSR_AUTO_RELEASE_EN
    do_reset();
    next_tick(t_env, t_busy, t_done);
    atk = 32'h4000_0000; dec = 32'h1000_0000; rls = 32'h1000_0000; sus = 16'h3000;
    sus_ticks = 16'd3;
    pulse(1, 0);
    expect_tick("au0", 16'h0000, 1'b1);
    expect_tick("au1", 16'h4000, 1'b1);
    expect_tick("au2", 16'h3000, 1'b1);
    expect_tick("au3", 16'h3000, 1'b1);
    expect_tick("au4", 16'h3000, 1'b1);
    expect_tick("au5", 16'h3000, 1'b1);
    expect_tick("au6", 16'h2000, 1'b1);
`endif

    // Randomized traffic, checked by the scoreboard
    for (int i = 0; i < 60; i++) begin
      int w;
      w = $urandom_range(0, 20);
      repeat (w) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        atk = rnd_step(); dec = rnd_step(); rls = rnd_step();
        sus = 16'($urandom);
`ifdef ADSR_AUTO_RELEASE_EN
        sus_ticks = 16'($urandom_range(0, 4));
`endif
      end
      case ($urandom_range(0, 3))
        0, 1: pulse(1, 0);
        2: pulse(0, 1);
        default: pulse(1, 1);
      endcase
    end

    // Reset in the middle of a release
    do_reset();
    next_tick(t_env, t_busy, t_done);
    atk = 32'h4000_0000; dec = 32'h1000_0000; rls = 32'h0100_0000; sus = 16'h3000;
`ifdef ADSR_AUTO_RELEASE_EN
    sus_ticks = 16'd0;
`endif
    pulse(1, 0);
    expect_tick("mr0", 16'h0000, 1'b1);
    expect_tick("mr1", 16'h4000, 1'b1);
    expect_tick("mr2", 16'h3000, 1'b1);
    pulse(0, 1);
    expect_tick("mr3", 16'h3000, 1'b1);
    expect_tick("mr4", 16'h2F00, 1'b1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("mr_rst_env", longint'(env), 0);
    check("mr_rst_busy", longint'(busy), 0);
    check("mr_rst_done", longint'(done), 0);
    seen_done = 0;
    repeat (3) begin @(posedge clk); #1; if (done) seen_done = 1; end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (done) seen_done = 1; end
    check("mr_no_done", longint'(seen_done), 0);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
